uart_tx_framer: RTL

// - Serialises one parallel word per handshake into an asynchronous UART frame on tx.
// - Frame: start(0), DATA_BITS LSB-first, optional parity, 1 or 2 stop(1).
// - Bit timing comes from the baud generator's baud_tick: 1-cycle pulse, one per bit period.
// - Sits between the host-side byte source and the serial pin.

---
 rtl/uart_tx_framer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS LSB-first, optional parity, 1 or 2 stop bits.
// Optional line-break generation is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_framer #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  state_t                 state_reg, state_next;
  logic [DATA_BITS-1:0]   shreg_reg, shreg_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic                   par_en_reg, par_en_next;
  logic                   par_bit_reg, par_bit_next;
  logic                   two_stop_reg, two_stop_next;
  logic                   tx_reg, tx_next;
  logic                   tx_ready_reg, tx_ready_next;
  logic                   tx_busy_reg, tx_busy_next;
  logic                   tx_done_reg, tx_done_next;
  logic                   break_req;

`ifdef UART_TX_BREAK_EN
  assign break_req = send_break;
`else
  assign break_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      bit_idx_reg  <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
      tx_reg       <= 1'b1;
      tx_ready_reg <= 1'b1;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      bit_idx_reg  <= bit_idx_next;
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
      two_stop_reg <= two_stop_next;
      tx_reg       <= tx_next;
      tx_ready_reg <= tx_ready_next;
      tx_busy_reg  <= tx_busy_next;
      tx_done_reg  <= tx_done_next;
    end
  end

  // Next-state and datapath; the parity bit is resolved at accept so later
  // changes to tx_data or parity_odd cannot disturb the frame.
  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    bit_idx_next  = bit_idx_reg;
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
    two_stop_next = two_stop_reg;
    tx_done_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (tx_valid && tx_ready_reg) begin
          shreg_next    = tx_data;
          par_en_next   = parity_en;
          par_bit_next  = (^tx_data) ^ parity_odd;
          two_stop_next = two_stop;
          state_next    = ALIGN;
        end
      end
      ALIGN: begin
        if (baud_tick) state_next = START;
      end
      START: begin
        if (baud_tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_reg == LAST_IDX) begin
            state_next = par_en_reg ? PARITY : STOP1;
          end else begin
            shreg_next   = shreg_reg >> 1;
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) state_next = STOP1;
      end
      STOP1: begin
        if (baud_tick) begin
          if (two_stop_reg) begin
            state_next = STOP2;
          end else begin
            state_next   = IDLE;
            tx_done_next = 1'b1;
          end
        end
      end
      STOP2: begin
        if (baud_tick) begin
          state_next   = IDLE;
          tx_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so that they register in step with it.
  always_comb begin
    tx_next       = 1'b1;
    tx_ready_next = 1'b0;
    tx_busy_next  = 1'b1;

    unique case (state_next)
      IDLE: begin
        tx_next       = ~break_req;
        tx_ready_next = ~break_req;
        tx_busy_next  = break_req;
      end
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = par_bit_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx       = tx_reg;
  assign tx_ready = tx_ready_reg;
  assign tx_busy  = tx_busy_reg;
  assign tx_done  = tx_done_reg;

endmodule
